// File: rtl/gen_master_arbiter_if.sv
// Avalon-MM bundle between NUM_REQ generator masters, the arbiter and the SDRAM bridge.
// The arbiter takes the slave modport; the surrounding environment takes the master modport.
interface gen_master_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
);
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]        req_waitrequest;
   logic [DATA_W-1:0]         req_readdata;
   logic [NUM_REQ-1:0]        req_readdatavalid;
   logic [ADDR_W-1:0]         master_address;
   logic                      master_read;
   logic                      master_write;
   logic [DATA_W-1:0]         master_writedata;
   logic                      master_waitrequest;
   logic [DATA_W-1:0]         master_readdata;
   logic                      master_readdatavalid;

   modport slave (
      input  req_address, req_read, req_write, req_writedata,
      output req_waitrequest, req_readdata, req_readdatavalid,
      output master_address, master_read, master_write, master_writedata,
      input  master_waitrequest, master_readdata, master_readdatavalid
   );

   modport master (
      output req_address, req_read, req_write, req_writedata,
      input  req_waitrequest, req_readdata, req_readdatavalid,
      input  master_address, master_read, master_write, master_writedata,
      output master_waitrequest, master_readdata, master_readdatavalid
   );
endinterface

// File: rtl/gen_master_arbiter.sv
// Round-robin sharing of one Avalon-MM SDRAM port between NUM_REQ move-generator masters,
// with in-order read-return routing. Define ARB_LOCK_EN to keep a grant for up to LOCK_MAX commands.
module gen_master_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned RD_FIFO_DEPTH = 8,
   parameter int unsigned LOCK_MAX      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   gen_master_arbiter_if.slave  bus,
   output logic                 rd_err
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]         state, state_nx;
   logic [ID_W-1:0]    grant_id, grant_nx;
   logic [ID_W-1:0]    rr_ptr, rr_nx;
   logic [ID_W-1:0]    next_id;
   logic [ID_W-1:0]    pick_id;
   logic               pick_found;
   logic [NUM_REQ-1:0] req_any;
   logic               g_read, g_write, stall, accept, push, pop;
   logic [NUM_REQ-1:0] rdv_nx;

   logic [ID_W-1:0]    fifo_mem [RD_FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_full, fifo_empty;

`ifdef ARB_LOCK_EN
   localparam int unsigned LCK_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   logic [LCK_W-1:0]   lock_cnt, lock_nx;
`endif

   assign req_any    = bus.req_read | bus.req_write;
   assign fifo_full  = (count == CNT_W'(RD_FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign next_id    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // First requester at or after the round-robin pointer
   always_comb begin
      pick_id    = rr_ptr;
      pick_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_any[ID_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
            pick_id    = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            pick_found = 1'b1;
         end
      end
   end

   // Granted requester's command; a simultaneous read and write resolves to the read
   assign g_read  = bus.req_read[grant_id];
   assign g_write = bus.req_write[grant_id] & ~bus.req_read[grant_id];
   assign stall   = g_read & fifo_full;

   always_comb begin
      state_nx                 = state;
      grant_nx                 = grant_id;
      rr_nx                    = rr_ptr;
`ifdef ARB_LOCK_EN
      lock_nx                  = lock_cnt;
`endif
      accept                   = 1'b0;
      bus.master_address       = '0;
      bus.master_writedata     = '0;
      bus.master_read          = 1'b0;
      bus.master_write         = 1'b0;
      bus.req_waitrequest      = '1;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               grant_nx = pick_id;
               state_nx = ST_GRANT;
            end
         end
         ST_GRANT: begin
            bus.master_address         = bus.req_address[32'(grant_id)*ADDR_W +: ADDR_W];
            bus.master_writedata       = bus.req_writedata[32'(grant_id)*DATA_W +: DATA_W];
            bus.master_read            = g_read & ~stall;
            bus.master_write           = g_write;
            bus.req_waitrequest[grant_id] = bus.master_waitrequest | stall;
            accept = (bus.master_read | bus.master_write) & ~bus.master_waitrequest;
            if (accept) begin
               rr_nx = next_id;
`ifdef ARB_LOCK_EN
               if (lock_cnt == LCK_W'(LOCK_MAX - 1)) begin
                  state_nx = ST_IDLE;
                  lock_nx  = '0;
               end else begin
                  lock_nx  = lock_cnt + LCK_W'(1);
               end
`else
               state_nx = ST_IDLE;
`endif
            end else if (!(g_read | g_write)) begin
               state_nx = ST_IDLE;
`ifdef ARB_LOCK_EN
               lock_nx  = '0;
`endif
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign push = accept & bus.master_read;
   assign pop  = bus.master_readdatavalid & ~fifo_empty;

   // One-hot return routing from the oldest outstanding issuer
   always_comb begin
      rdv_nx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rdv_nx[i] = pop & (fifo_mem[rd_ptr] == ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= ST_IDLE;
         grant_id              <= '0;
         rr_ptr                <= '0;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         count                 <= '0;
         rd_err                <= 1'b0;
         bus.req_readdatavalid <= '0;
         bus.req_readdata      <= '0;
`ifdef ARB_LOCK_EN
         lock_cnt              <= '0;
`endif
      end else begin
         state    <= state_nx;
         grant_id <= grant_nx;
         rr_ptr   <= rr_nx;
`ifdef ARB_LOCK_EN
         lock_cnt <= lock_nx;
`endif
         if (push) begin
            fifo_mem[wr_ptr] <= grant_id;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (bus.master_readdatavalid && fifo_empty) rd_err <= 1'b1;
         bus.req_readdatavalid <= rdv_nx;
         if (pop) bus.req_readdata <= bus.master_readdata;
      end
   end
endmodule

// File: tb/tb_gen_master_arbiter.sv
// Scoreboard bench for gen_master_arbiter: requester agents, reactive SDRAM model and an
// independent read-return monitor, with a round-robin grant-order reference.
module tb_gen_master_arbiter;
   localparam int unsigned N     = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;
   localparam int          LMAX  = 16;
`ifdef ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   typedef struct { bit rd; logic [31:0] addr; logic [31:0] data; } cmd_t;
   typedef struct { int id; logic [31:0] data; } exp_t;

   logic clk;
   logic rst;
   logic rd_err;

   gen_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   gen_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
                        .RD_FIFO_DEPTH(DEPTH), .LOCK_MAX(LMAX)) dut (
      .clk(clk), .rst(rst), .bus(bus), .rd_err(rd_err));

   cmd_t        cq [N][$];
   exp_t        exp_q[$];
   logic [31:0] pending[$];
   int          acc_id_log[$];
   int          acc_cyc_log[$];
   int          checks, failures, cycle;
   int          wait_pct, rdv_pct, beats_allowed, force_wait;
   int          t3_wait_seen, reads_acc, last_rdv_cyc, last_rd_acc_cyc;
   bit          spurious, due_valid, err_exp, mon_en, t3_mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] sdram_data(input logic [31:0] a);
      return (a == 32'h40) ? 32'h0000_00FF : (a ^ 32'hC3A5_5A3C) + 32'd17;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int queued();
      int s = pending.size() + exp_q.size();
      for (int i = 0; i < N; i++) s += cq[i].size();
      return s;
   endfunction

   // Decide what happens at the coming clock edge from the settled bus values
   task automatic observe();
      int   nacc = 0;
      int   who  = -1;
      bit   macc;
      cmd_t c;
      for (int i = 0; i < N; i++)
         if ((bus.req_read[i] | bus.req_write[i]) && !bus.req_waitrequest[i]) begin
            nacc++;
            who = i;
         end
      macc = (bus.master_read | bus.master_write) && !bus.master_waitrequest;
      if ((bus.master_read | bus.master_write) && bus.master_waitrequest)
         check("wait_all_stalled", bus.req_waitrequest, {N{1'b1}});
      if (t3_mode && bus.master_write && cq[2].size() > 0) begin
         check("t3_addr_stable", bus.master_address, cq[2][0].addr);
         check("t3_wdata_stable", bus.master_writedata, cq[2][0].data);
         if (bus.master_waitrequest) t3_wait_seen++;
      end
      if (nacc > 0 || macc) begin
         check("accept_count", nacc, macc);
         if (who >= 0) begin
            c = cq[who].pop_front();
            if (macc) begin
               check("cmd_type", bus.master_read, c.rd);
               check("cmd_addr", bus.master_address, c.addr);
               if (!c.rd) check("cmd_wdata", bus.master_writedata, c.data);
               acc_id_log.push_back(who);
               acc_cyc_log.push_back(cycle);
               if (c.rd) begin
                  exp_q.push_back('{who, sdram_data(c.addr)});
                  pending.push_back(c.addr);
                  reads_acc++;
                  last_rd_acc_cyc = cycle;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      cycle++;
      for (int i = 0; i < N; i++) begin
         if (cq[i].size() > 0) begin
            bus.req_read[i]                 = cq[i][0].rd;
            bus.req_write[i]                = !cq[i][0].rd;
            bus.req_address[i*AW +: AW]     = cq[i][0].addr;
            bus.req_writedata[i*DW +: DW]   = cq[i][0].data;
         end else begin
            bus.req_read[i]  = 1'b0;
            bus.req_write[i] = 1'b0;
         end
      end
      bus.master_readdatavalid = 1'b0;
      due_valid = 1'b0;
      if (spurious) begin
         bus.master_readdatavalid = 1'b1;
         bus.master_readdata      = $urandom;
         err_exp  = 1'b1;
         spurious = 1'b0;
      end else if (pending.size() > 0 && beats_allowed > 0 && $urandom_range(99) < rdv_pct) begin
         bus.master_readdatavalid = 1'b1;
         bus.master_readdata      = sdram_data(pending.pop_front());
         due_valid     = 1'b1;
         beats_allowed--;
         last_rdv_cyc  = cycle;
      end
      #1;
      if ((bus.master_read | bus.master_write) && force_wait > 0) begin
         bus.master_waitrequest = 1'b1;
         force_wait--;
      end else begin
         bus.master_waitrequest = ($urandom_range(99) < wait_pct);
      end
      #1;
      observe();
   endtask

   task automatic idle_inputs();
      bus.req_read = '0; bus.req_write = '0; bus.req_address = '0; bus.req_writedata = '0;
      bus.master_waitrequest = 1'b0; bus.master_readdata = '0; bus.master_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      due_valid = 1'b0; err_exp = 1'b0; spurious = 1'b0; force_wait = 0;
      pending.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) cq[i].delete();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_waitrequest", bus.req_waitrequest, {N{1'b1}});
      check("rst_master_read", bus.master_read, 0);
      check("rst_master_write", bus.master_write, 0);
      check("rst_master_address", bus.master_address, 0);
      check("rst_master_wdata", bus.master_writedata, 0);
      check("rst_rdv", bus.req_readdatavalid, 0);
      check("rst_rdata", bus.req_readdata, 0);
      check("rst_rd_err", rd_err, 0);
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (queued() > 0 && n < budget) begin
         step();
         n++;
      end
      if (queued() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_items_left required=0", queued());
         for (int i = 0; i < N; i++) cq[i].delete();
         pending.delete();
         exp_q.delete();
      end
      repeat (3) step();
   endtask

   // Expected grant sequence from round-robin rules with every requester streaming
   task automatic check_order(input int cnt_in[N]);
      int cnt[N];
      int exp_ids[$];
      int p = 0, left = 0, sel, take;
      for (int i = 0; i < N; i++) begin cnt[i] = cnt_in[i]; left += cnt[i]; end
      while (left > 0) begin
         sel = -1;
         for (int k = 0; k < N; k++)
            if (sel < 0 && cnt[(p + k) % N] > 0) sel = (p + k) % N;
         take = LOCK ? ((cnt[sel] < LMAX) ? cnt[sel] : LMAX) : 1;
         repeat (take) exp_ids.push_back(sel);
         cnt[sel] -= take;
         left     -= take;
         p = (sel + 1) % N;
      end
      check("order_len", acc_id_log.size(), exp_ids.size());
      for (int j = 0; j < acc_id_log.size() && j < exp_ids.size(); j++) begin
         check("order_id", acc_id_log[j], exp_ids[j]);
`ifdef ARB_LOCK_EN
         if (j > 0 && exp_ids[j] == exp_ids[j-1])
            check("lock_gap", acc_cyc_log[j] - acc_cyc_log[j-1], 1);
`else
         if (j > 0) check("bubble_gap", acc_cyc_log[j] - acc_cyc_log[j-1], 2);
`endif
      end
   endtask

   // Read-return scoreboard: each forwarded beat must surface one cycle later at its issuer
   always @(posedge clk) begin
      exp_t e;
      logic [N-1:0] oh;
      #3;
      if (mon_en && !rst) begin
         if (due_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rdv_unexpected actual=%0h required=none", bus.req_readdatavalid);
            end else begin
               e  = exp_q.pop_front();
               oh = '0;
               oh[e.id] = 1'b1;
               check("rdv_onehot", bus.req_readdatavalid, oh);
               check("rdata", bus.req_readdata, e.data);
            end
         end else begin
            check("rdv_quiet", bus.req_readdatavalid, 0);
         end
         check("rd_err", rd_err, err_exp);
      end
   end

   initial begin
      int   cnt[N];
      cmd_t c;
      checks = 0; failures = 0; cycle = 0; mon_en = 1'b0; t3_mode = 1'b0;
      wait_pct = 0; rdv_pct = 100; beats_allowed = 1_000_000;
      reads_acc = 0; last_rdv_cyc = 0; last_rd_acc_cyc = 0; t3_wait_seen = 0;
      rst = 1'b1;
      idle_inputs();
      do_reset();

      // Single read from requester 0
      cq[0].push_back('{1'b1, 32'h40, 32'h0});
      drain(200);

      // All four requesters stream writes
      do_reset();
      acc_id_log.delete(); acc_cyc_log.delete();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 3; k++) cq[i].push_back('{1'b0, 32'(i*256 + k*4), $urandom});
         cnt[i] = 3;
      end
      drain(500);
      check_order(cnt);

      // Requester 1 long burst against requester 3
      do_reset();
      acc_id_log.delete(); acc_cyc_log.delete();
      for (int k = 0; k < 64; k++) cq[1].push_back('{1'b0, 32'h1000 + 32'(k*4), $urandom});
      for (int k = 0; k < 4; k++)  cq[3].push_back('{1'b0, 32'h3000 + 32'(k*4), $urandom});
      cnt[0] = 0; cnt[1] = 64; cnt[2] = 0; cnt[3] = 4;
      drain(1000);
      check_order(cnt);

      // SDRAM stalls a write from requester 2 for five cycles
      cq[2].push_back('{1'b0, 32'h2000, 32'hDEAD_BEEF});
      force_wait = 5; t3_wait_seen = 0; t3_mode = 1'b1;
      drain(100);
      t3_mode = 1'b0;
      check("t3_wait_cycles", t3_wait_seen, 5);

      // Nine reads with no returns: FIFO fills at eight
      beats_allowed = 0; reads_acc = 0;
      for (int k = 0; k < 9; k++) cq[k % N].push_back('{1'b1, 32'h100 + 32'(k*4), 32'h0});
      repeat (40) step();
      check("full_accepts", reads_acc, 8);
      check("full_master_read", bus.master_read, 0);
      beats_allowed = 1;
      for (int n = 0; n < 20 && reads_acc < 9; n++) step();
      check("ninth_accepts", reads_acc, 9);
      check("ninth_latency", last_rd_acc_cyc - last_rdv_cyc, 1);
      beats_allowed = 1_000_000;
      drain(300);

      // Return beat with nothing outstanding
      spurious = 1'b1;
      repeat (5) step();
      cq[1].push_back('{1'b1, 32'h4444, 32'h0});
      drain(100);
      do_reset();

      // Randomized mixed traffic
      wait_pct = 30; rdv_pct = 40;
      for (int k = 0; k < 300; k++) begin
         c.rd   = $urandom_range(1);
         c.addr = $urandom & 32'hFFFF_FFFC;
         c.data = $urandom;
         cq[$urandom_range(N-1)].push_back(c);
      end
      drain(6000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
